mem_sram_responder: RTL
=======================

# mem_sram_responder

Responder end of the data-memory request/response channel. Accepts one word-aligned request at a time on `mem_req` (address, write enable, byte enables, write data), applies it to an internal word-organised SRAM array after a configurable access latency, and returns exactly one response word on `mem_resp` per accepted request. Sits on the memory side of the exec-stage memory unit, in simulation and FPGA tops, as the default data memory.

## Interface
- `DEPTH`, 1024: array size in 32-bit words; power of two, ≥ 2.
- `BASE`, 32'h8000_0000: byte address of word 0; aligned to `4*DEPTH`.
- `LATENCY`, 1: cycles from request handshake to `mem_resp.valid`; integer ≥ 1.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-low (asserted when 0).
- `mem_req`  decoupled.in  —  request: `data.a` (addr, 32), `data.we` (1), `data.be` (4), `data.d` (32); `valid`/`ready`.
- `mem_resp`  decoupled.out  —  response: `data` (mtrans, 32); `valid`/`ready`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `mem_req.ready`=1. On `mem_req.valid && mem_req.ready`, latch a, we, be, d. If LATENCY==1, perform the access in the next cycle and enter RESP. Otherwise load the counter with LATENCY-2 and enter WAIT.
- WAIT: `mem_req.ready`=0. Decrement the counter each cycle. When the counter is 0, perform the access and enter RESP.
- RESP: `mem_req.ready`=0, `mem_resp.valid`=1. `mem_resp.data` is held stable until `mem_resp.ready`; on handshake return to IDLE.
- Only one request is outstanding at a time. A new request is never accepted in the same cycle as a response handshake.
- Address decode:
  - in range iff `BASE <= a < BASE + 4*DEPTH` (unsigned compare, no 32-bit wrap);
  - index = `(a - BASE)[$clog2(DEPTH)+1:2]`;
  - `a[1:0]` is ignored; the initiator always presents aligned addresses.
- Write (we=1, in range): update byte lane i iff `be[i]`. Lanes with `be[i]`=0 keep their old value. Response data = 32'h0.
- Read (we=0, in range): response data = the full stored word. `be` is ignored, because the initiator performs lane shifting and extension.
- Out of range: the write is dropped. The response is still produced with data 32'h0, so the initiator never hangs.
- The access happens in the cycle of the WAIT→RESP or IDLE→RESP transition. A read issued after a write handshake completes returns the written data.
- Array contents are not affected by reset and are X at power-up in simulation.

## Timing
- Reset (`rst`=0 at a clock edge), effective the next cycle:
  - state = IDLE, counter = 0;
  - `mem_req.ready`=1, `mem_resp.valid`=0, `mem_resp.data`=32'h0.
- Reset mid-operation drops the latched request with no response. A write whose access cycle has not yet occurred is not performed.
- Latency: request handshake at edge N gives `mem_resp.valid`=1 from edge N+LATENCY.
- Throughput: with `mem_resp.ready` held at 1, one transaction per LATENCY+1 cycles.
- `mem_req.ready` depends only on state; it never depends combinationally on `mem_req.valid`.
- `mem_resp.valid` and `mem_resp.data` are registered. There is no combinational path from any input to any output.
- Backpressure: while `mem_resp.ready`=0 in RESP, hold valid and data indefinitely and accept no requests.
- `mem_req.data` is sampled only at the handshake edge. Later changes by the initiator have no effect.

## Test plan
- LATENCY=1. Write a=BASE+8, be=4'b1111, d=32'hDEADBEEF. Expected: response 32'h0 one cycle after the handshake. Then read a=BASE+8. Expected: response 32'hDEADBEEF.
- Byte lanes: start with word 32'h11223344. Write be=4'b0100, d=32'h00AA0000, then read. Expected: 32'h11AA3344. Repeat with be=4'b1100, d=32'hBBCC0000. Expected: 32'hBBCC3344.
- LATENCY=3. Read request handshake at cycle 10. Expected: `mem_resp.valid` rises at cycle 13 and `mem_req.ready`=0 during cycles 11–13.
- Backpressure: hold `mem_resp.ready`=0 for 5 cycles in RESP with `mem_req.valid`=1. Expected: valid and data stable, no second handshake. On ready=1, exactly one response handshake, then the second request is accepted the following cycle.
- Out of range: write to a=BASE+4*DEPTH, then read a=BASE-4. Expected: both return 32'h0 and no array word changes. Write to BASE+4*(DEPTH-1) succeeds.
- Reset mid-operation: LATENCY=4, write handshake, assert `rst`=0 during WAIT. Expected: the next cycle shows `mem_resp.valid`=0 and `mem_req.ready`=1, no response is produced, and a subsequent read of that address returns the old data.

Source files
------------

// File: rtl/mem_sram_responder_if.sv
// Request/response channel bundles between the memory unit and the data SRAM.

// Request channel: one word-aligned access per valid/ready handshake.
interface mem_req_if;
   logic        valid;
   logic        ready;
   logic [31:0] a;
   logic        we;
   logic [3:0]  be;
   logic [31:0] d;

   modport master (output valid, a, we, be, d, input ready);
   modport slave  (input valid, a, we, be, d, output ready);
endinterface

// Response channel: one word per accepted request.
interface mem_resp_if;
   logic        valid;
   logic        ready;
   logic [31:0] data;

   modport master (output valid, data, input ready);
   modport slave  (input valid, data, output ready);
endinterface

// File: rtl/mem_sram_responder.sv
// Data-memory responder: single outstanding request, fixed access latency,
// word-organised array with byte-lane writes and a zero response out of range.
module mem_sram_responder #(
   parameter int unsigned DEPTH   = 1024,
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int unsigned LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst,
   mem_req_if.slave   mem_req,
   mem_resp_if.master mem_resp
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam int unsigned CW       = $clog2(LATENCY + 1);
   localparam bit          DIRECT   = (LATENCY == 1);
   localparam logic [CW-1:0] CNT_LOAD = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;
   localparam logic [32:0] END_ADDR = 33'(BASE) + 33'(4 * DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_a;
   logic          r_we;
   logic [3:0]    r_be;
   logic [31:0]   r_d;
   logic          r_req_ready;
   logic          r_resp_valid;
   logic [31:0]   r_resp_data;
   logic [31:0]   r_mem [DEPTH];

   logic          w_req_fire;
   logic          w_access;
   logic [31:0]   w_acc_a;
   logic          w_acc_we;
   logic [3:0]    w_acc_be;
   logic [31:0]   w_acc_d;
   logic [31:0]   w_off;
   logic          w_in_range;
   logic [AW-1:0] w_idx;
   logic          w_wr_en;
   logic [31:0]   w_resp_word;
   logic          w_unused_off;

   assign w_req_fire = mem_req.valid && r_req_ready;

   // Access fires at the handshake edge when LATENCY==1, else when the wait count expires.
   assign w_access = (DIRECT && (r_state == S_IDLE) && w_req_fire) ||
                     ((r_state == S_WAIT) && (r_cnt == '0));

   // The direct path uses the live request fields; delayed accesses use the latched copy.
   assign w_acc_a  = (r_state == S_IDLE) ? mem_req.a  : r_a;
   assign w_acc_we = (r_state == S_IDLE) ? mem_req.we : r_we;
   assign w_acc_be = (r_state == S_IDLE) ? mem_req.be : r_be;
   assign w_acc_d  = (r_state == S_IDLE) ? mem_req.d  : r_d;

   // Decode in 33 bits so addresses near the top of the space cannot wrap into range.
   assign w_off        = w_acc_a - BASE;
   assign w_in_range   = ({1'b0, w_acc_a} >= {1'b0, BASE}) && ({1'b0, w_acc_a} < END_ADDR);
   assign w_idx        = w_off[AW+1:2];
   assign w_unused_off = ^{w_off[31:AW+2], w_off[1:0]};

   assign w_wr_en     = rst && w_access && w_acc_we && w_in_range;
   assign w_resp_word = (w_acc_we || !w_in_range) ? 32'h0 : r_mem[w_idx];

   // Array write with per-lane enables; contents are never reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (w_acc_be[i]) begin
               r_mem[w_idx][8*i +: 8] <= w_acc_d[8*i +: 8];
            end
         end
      end
   end

   // Control FSM with registered handshake outputs and response word.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_data  <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req_fire) begin
                  r_a         <= mem_req.a;
                  r_we        <= mem_req.we;
                  r_be        <= mem_req.be;
                  r_d         <= mem_req.d;
                  r_req_ready <= 1'b0;
                  if (DIRECT) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_data  <= w_resp_word;
                  end else begin
                     r_cnt   <= CNT_LOAD;
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_data  <= w_resp_word;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_RESP: begin
               if (mem_resp.ready) begin
                  r_state      <= S_IDLE;
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_resp_valid <= 1'b0;
               r_req_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign mem_req.ready  = r_req_ready;
   assign mem_resp.valid = r_resp_valid;
   assign mem_resp.data  = r_resp_data;

endmodule
